cpu_if_arbiter: RTL and testbench

//  Single-clock N:1 CPU-bus arbiter: NUM_PORTS CPU slave ports share one CPU master port.

---
 rtl/cpu_if_arbiter.sv | 173 +++++++++++++++++
 tb/tb_cpu_if_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_if_arbiter.sv
// N:1 CPU-bus arbiter: round-robin grant, one transaction in flight, per-port
// response routing, and a grant-to-completion timeout that returns an error.
module cpu_if_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                             cpu_clk,
    input  logic                             cpu_reset,
    input  logic [NUM_PORTS-1:0]             cpu_s_write,
    input  logic [NUM_PORTS-1:0]             cpu_s_read,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  cpu_s_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  cpu_s_write_data,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  cpu_s_read_data,
    output logic [NUM_PORTS-1:0]             cpu_s_access_ready,
    output logic [NUM_PORTS-1:0]             cpu_s_access_complete,
    output logic [NUM_PORTS-1:0]             cpu_s_access_error,
    output logic                             cpu_m_write,
    output logic                             cpu_m_read,
    output logic [ADDR_WIDTH-1:0]            cpu_m_address,
    output logic [DATA_WIDTH-1:0]            cpu_m_write_data,
    input  logic [DATA_WIDTH-1:0]            cpu_m_read_data,
    input  logic                             cpu_m_access_ready,
    input  logic                             cpu_m_access_complete,
    output logic [1:0]                       o_dbg_state
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [PW-1:0]         r_rr;
    logic [PW-1:0]         r_grant;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_err;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_rdata [NUM_PORTS];

    logic [NUM_PORTS-1:0]  w_req;
    logic [ADDR_WIDTH-1:0] w_s_addr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] w_s_wdata [NUM_PORTS];
    logic                  w_found;
    logic [PW-1:0]         w_gnt;
    int                    w_idx;
    logic                  w_expire;
    logic                  w_to_resp;
    logic                  w_resp_err;
    logic [NUM_PORTS-1:0]  w_gnt_oh;
    logic [NUM_PORTS-1:0]  w_resp_oh;

    assign w_req = cpu_s_write | cpu_s_read;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_s_addr[p]  = cpu_s_address[p*ADDR_WIDTH +: ADDR_WIDTH];
            w_s_wdata[p] = cpu_s_write_data[p*DATA_WIDTH +: DATA_WIDTH];
            cpu_s_read_data[p*DATA_WIDTH +: DATA_WIDTH] = r_rdata[p];
        end
    end

    // First requester at or after the round-robin pointer, wrapping past the top port.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            w_idx = int'(r_rr) + i;
            if (w_idx >= NUM_PORTS) w_idx = w_idx - NUM_PORTS;
            if (!w_found && w_req[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = PW'(w_idx);
            end
        end
    end

    // The grant cycle counts toward the budget, so the error completion lands
    // exactly TIMEOUT_CYCLES cycles after the grant.
    always_comb begin
        if (TIMEOUT_CYCLES == 0) w_expire = 1'b0;
        else                     w_expire = (int'(r_count) + 1 >= TIMEOUT_CYCLES - 1);
    end

    always_comb begin
        w_state_next = r_state;
        w_to_resp    = 1'b0;
        w_resp_err   = 1'b0;
        case (r_state)
            S_IDLE: if (w_found) w_state_next = S_REQ;
            S_REQ: begin
                if (cpu_m_access_ready && cpu_m_access_complete) begin
                    w_state_next = S_RESP;
                    w_to_resp    = 1'b1;
                end else if (w_expire) begin
                    w_state_next = S_RESP;
                    w_to_resp    = 1'b1;
                    w_resp_err   = 1'b1;
                end else if (cpu_m_access_ready) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cpu_m_access_complete) begin
                    w_state_next = S_RESP;
                    w_to_resp    = 1'b1;
                end else if (w_expire) begin
                    w_state_next = S_RESP;
                    w_to_resp    = 1'b1;
                    w_resp_err   = 1'b1;
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) r_state <= S_IDLE;
        else           r_state <= w_state_next;
    end

    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            r_rr    <= '0;
            r_grant <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_count <= '0;
            for (int p = 0; p < NUM_PORTS; p++) r_rdata[p] <= '0;
        end else begin
            if (r_state == S_IDLE && w_found) begin
                r_grant <= w_gnt;
                r_write <= cpu_s_write[w_gnt];
                r_addr  <= w_s_addr[w_gnt];
                r_wdata <= w_s_wdata[w_gnt];
                r_rr    <= (w_gnt == PW'(NUM_PORTS - 1)) ? '0 : w_gnt + 1'b1;
                r_count <= '0;
            end else if ((r_state == S_REQ || r_state == S_WAIT) && r_count != {CW{1'b1}}) begin
                r_count <= r_count + 1'b1;
            end
            if (w_to_resp) begin
                r_err            <= w_resp_err;
                r_rdata[r_grant] <= w_resp_err ? '0 : cpu_m_read_data;
            end
        end
    end

    assign w_gnt_oh  = {{(NUM_PORTS-1){1'b0}}, 1'b1} << w_gnt;
    assign w_resp_oh = {{(NUM_PORTS-1){1'b0}}, 1'b1} << r_grant;

    // Ready is combinational in the grant cycle; masked while reset is held.
    assign cpu_s_access_ready    = (r_state == S_IDLE && w_found && !cpu_reset) ? w_gnt_oh : '0;
    assign cpu_s_access_complete = (r_state == S_RESP) ? w_resp_oh : '0;
    assign cpu_s_access_error    = cpu_s_access_complete & {NUM_PORTS{r_err}};
    assign cpu_m_write           = (r_state == S_REQ) &  r_write;
    assign cpu_m_read            = (r_state == S_REQ) & ~r_write;
    assign cpu_m_address         = r_addr;
    assign cpu_m_write_data      = r_wdata;
    assign o_dbg_state           = r_state;

endmodule

// File: tb/tb_cpu_if_arbiter.sv
// Directed bench for cpu_if_arbiter: completions are matched against an
// expected queue of {port, error, read_data} pushed as stimulus is driven.
module tb_cpu_if_arbiter;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int EW = 2 + 1 + DW;

    logic             cpu_clk = 1'b0;
    logic             cpu_reset;
    logic [NP-1:0]    cpu_s_write;
    logic [NP-1:0]    cpu_s_read;
    logic [NP*AW-1:0] cpu_s_address;
    logic [NP*DW-1:0] cpu_s_write_data;
    logic [NP*DW-1:0] cpu_s_read_data;
    logic [NP-1:0]    cpu_s_access_ready;
    logic [NP-1:0]    cpu_s_access_complete;
    logic [NP-1:0]    cpu_s_access_error;
    logic             cpu_m_write;
    logic             cpu_m_read;
    logic [AW-1:0]    cpu_m_address;
    logic [DW-1:0]    cpu_m_write_data;
    logic [DW-1:0]    cpu_m_read_data;
    logic             cpu_m_access_ready;
    logic             cpu_m_access_complete;
    logic [1:0]       o_dbg_state;

    int               n_checks = 0;
    int               n_errors = 0;
    logic [EW-1:0]    exp_q[$];

    wire any_out = |{cpu_s_read_data, cpu_s_access_ready, cpu_s_access_complete,
                     cpu_s_access_error, cpu_m_write, cpu_m_read, cpu_m_address,
                     cpu_m_write_data, o_dbg_state};

    cpu_if_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .cpu_clk(cpu_clk), .cpu_reset(cpu_reset),
        .cpu_s_write(cpu_s_write), .cpu_s_read(cpu_s_read),
        .cpu_s_address(cpu_s_address), .cpu_s_write_data(cpu_s_write_data),
        .cpu_s_read_data(cpu_s_read_data), .cpu_s_access_ready(cpu_s_access_ready),
        .cpu_s_access_complete(cpu_s_access_complete),
        .cpu_s_access_error(cpu_s_access_error),
        .cpu_m_write(cpu_m_write), .cpu_m_read(cpu_m_read),
        .cpu_m_address(cpu_m_address), .cpu_m_write_data(cpu_m_write_data),
        .cpu_m_read_data(cpu_m_read_data), .cpu_m_access_ready(cpu_m_access_ready),
        .cpu_m_access_complete(cpu_m_access_complete), .o_dbg_state(o_dbg_state)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int p, input logic wr, input logic rd,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_s_write[p] = wr;
        cpu_s_read[p]  = rd;
        cpu_s_address[p*AW +: AW]    = a;
        cpu_s_write_data[p*DW +: DW] = d;
    endtask

    function automatic logic [NP-1:0] oh(input int p);
        logic [NP-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    // Completion monitor: every completion strobe must match the queue head.
    always @(negedge cpu_clk) begin
        if (!cpu_reset) begin
            for (int p = 0; p < NP; p++) begin
                if (cpu_s_access_complete[p]) begin
                    logic [EW-1:0] got;
                    logic [EW-1:0] exp;
                    got = {2'(p), cpu_s_access_error[p], cpu_s_read_data[p*DW +: DW]};
                    n_checks++;
                    assert (exp_q.size() != 0) else begin
                        n_errors++;
                        $error("FAIL unexpected_complete: observed %h expected none", got);
                    end
                    if (exp_q.size() != 0) begin
                        exp = exp_q.pop_front();
                        assert (got === exp) else begin
                            n_errors++;
                            $error("FAIL completion: observed %h expected %h", got, exp);
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] d;
        int            p;

        cpu_reset             = 1'b1;
        cpu_s_write           = '0;
        cpu_s_read            = '0;
        cpu_s_address         = '0;
        cpu_s_write_data      = '0;
        cpu_m_read_data       = '0;
        cpu_m_access_ready    = 1'b0;
        cpu_m_access_complete = 1'b0;
        repeat (3) step();
        check("reset_outs", any_out, 0);
        cpu_reset = 1'b0;
        step();
        check("idle_outs", any_out, 0);

        // All four ports read continuously; downstream ready+complete every cycle.
        for (int q = 0; q < NP; q++) set_req(q, 1'b0, 1'b1, 32'h1000 + q * 16, '0);
        cpu_m_access_ready    = 1'b1;
        cpu_m_access_complete = 1'b1;
        for (int k = 0; k < 5; k++) begin
            p = k % NP;
            d = $urandom();
            #1;
            check("rr_ready", cpu_s_access_ready, oh(p));
            cpu_m_read_data = d;
            exp_q.push_back({2'(p), 1'b0, d});
            step();
            check("rr_m_addr", cpu_m_address, 32'h1000 + p * 16);
            check("rr_m_read", {cpu_m_write, cpu_m_read}, 2'b01);
            step();
            check("rr_complete", cpu_s_access_complete, oh(p));
            if (k == 4) begin
                cpu_s_read            = '0;
                cpu_m_access_ready    = 1'b0;
                cpu_m_access_complete = 1'b0;
            end
            step();
        end

        // Single read on port 2 with split ready/complete.
        set_req(2, 1'b0, 1'b1, 32'h0000_0100, '0);
        #1;
        check("t1_ready", cpu_s_access_ready, 4'b0100);
        step();
        cpu_s_read[2]      = 1'b0;
        cpu_m_access_ready = 1'b1;
        #1;
        check("t1_m_read", {cpu_m_write, cpu_m_read}, 2'b01);
        check("t1_m_addr", cpu_m_address, 32'h0000_0100);
        check("t1_ready_gone", cpu_s_access_ready, 0);
        step();
        cpu_m_access_ready = 1'b0;
        check("t1_m_dropped", {cpu_m_write, cpu_m_read}, 2'b00);
        check("t1_state_wait", o_dbg_state, 2);
        step();
        cpu_m_access_complete = 1'b1;
        cpu_m_read_data       = 32'hDEAD_BEEF;
        exp_q.push_back({2'd2, 1'b0, 32'hDEAD_BEEF});
        check("t1_no_early", cpu_s_access_complete, 0);
        step();
        cpu_m_access_complete = 1'b0;
        cpu_m_read_data       = '0;
        check("t1_complete", cpu_s_access_complete, 4'b0100);
        check("t1_error", cpu_s_access_error, 0);
        step();
        check("t1_hold", cpu_s_read_data[2*DW +: DW], 32'hDEAD_BEEF);

        // Write and read both asserted on port 1: write wins.
        set_req(1, 1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678);
        #1;
        check("t3_ready", cpu_s_access_ready, 4'b0010);
        step();
        set_req(1, 1'b0, 1'b0, '0, '0);
        cpu_m_access_ready    = 1'b1;
        cpu_m_access_complete = 1'b1;
        cpu_m_read_data       = 32'h0000_A5A5;
        exp_q.push_back({2'd1, 1'b0, 32'h0000_A5A5});
        check("t3_m_wr_rd", {cpu_m_write, cpu_m_read}, 2'b10);
        check("t3_m_addr", cpu_m_address, 32'h0000_0040);
        check("t3_m_wdata", cpu_m_write_data, 32'h1234_5678);
        step();
        cpu_m_access_ready    = 1'b0;
        cpu_m_access_complete = 1'b0;
        check("t3_complete", cpu_s_access_complete, 4'b0010);
        step();

        // Timeout: port 3 read, downstream never ready.
        set_req(3, 1'b0, 1'b1, 32'h0000_0300, '0);
        cpu_m_read_data = 32'hFFFF_FFFF;
        #1;
        check("t4_ready", cpu_s_access_ready, 4'b1000);
        exp_q.push_back({2'd3, 1'b1, 32'h0});
        for (int k = 1; k < TO; k++) begin
            step();
            cpu_s_read[3] = 1'b0;
            check("t4_m_read_held", {cpu_m_read, cpu_s_access_complete}, {1'b1, 4'b0000});
        end
        step();
        check("t4_m_dropped", {cpu_m_write, cpu_m_read}, 2'b00);
        check("t4_complete", cpu_s_access_complete, 4'b1000);
        check("t4_error", cpu_s_access_error, 4'b1000);

        // Late downstream completion in IDLE and a stray one in REQ are discarded.
        step();
        cpu_m_access_complete = 1'b1;
        cpu_m_read_data       = 32'h5555_5555;
        step();
        cpu_m_access_complete = 1'b0;
        check("t5_no_complete", cpu_s_access_complete, 0);
        check("t5_idle", o_dbg_state, 0);
        set_req(0, 1'b1, 1'b0, 32'h0000_0080, 32'hCAFE_0000);
        #1;
        check("t5_ready", cpu_s_access_ready, 4'b0001);
        step();
        set_req(0, 1'b0, 1'b0, '0, '0);
        cpu_m_access_complete = 1'b1;
        check("t5_m_write", {cpu_m_write, cpu_m_read}, 2'b10);
        check("t5_m_addr", cpu_m_address, 32'h0000_0080);
        step();
        cpu_m_access_complete = 1'b0;
        cpu_m_access_ready    = 1'b1;
        check("t5_stray_ignored", {o_dbg_state, cpu_s_access_complete}, {2'd1, 4'b0000});
        step();
        cpu_m_access_ready = 1'b0;
        check("t5_wait", o_dbg_state, 2);

        // Reset in WAIT drops the transaction and the round-robin pointer.
        cpu_reset = 1'b1;
        #1;
        check("t6_async_reset", any_out, 0);
        set_req(0, 1'b0, 1'b1, 32'h0000_0010, '0);
        set_req(2, 1'b0, 1'b1, 32'h0000_0020, '0);
        step();
        check("t6_reset_edge", any_out, 0);
        cpu_reset = 1'b0;
        #1;
        check("t6_first_grant", cpu_s_access_ready, 4'b0001);
        step();
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(2, 1'b0, 1'b0, '0, '0);
        cpu_m_access_ready    = 1'b1;
        cpu_m_access_complete = 1'b1;
        cpu_m_read_data       = 32'h0BAD_F00D;
        exp_q.push_back({2'd0, 1'b0, 32'h0BAD_F00D});
        check("t6_m_addr", cpu_m_address, 32'h0000_0010);
        step();
        cpu_m_access_ready    = 1'b0;
        cpu_m_access_complete = 1'b0;
        check("t6_complete", cpu_s_access_complete, 4'b0001);
        step();
        step();

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
